scale_controller: RTL
=====================

Name: scale_controller

Overview:
- Sequences the camera-scaling datapath.
- Owns the active scale mode (1x, 2x, 8/3x), cycles it on a user button pulse, and commits each change only at a frame boundary so a frame is never torn.
- Generates the frame-buffer read address for every display pixel. Produces a region/valid flag time-aligned with BRAM read data, so the downstream scale mux needs no counter compares.
- Sits between the video sig generator (hcount/vcount/new_frame) and the 240x320 camera frame buffer read port.

Parameters:
- FB_WIDTH, 240, frame-buffer columns (source x range 0..FB_WIDTH-1).
- FB_HEIGHT, 320, frame-buffer rows (source y range 0..FB_HEIGHT-1).
- READ_LATENCY, 2, frame-buffer read latency in cycles; valid_out is delayed by this many cycles beyond addr_out.

Ports:
- clk_in  input  1  pixel clock.
- rst_in  input  1  asynchronous, active-high reset.
- btn_pulse_in  input  1  single-cycle pulse (already debounced); requests the next scale mode.
- new_frame_in  input  1  single-cycle pulse at the first pixel of a frame.
- hcount_in  input  11  display column.
- vcount_in  input  10  display row.
- scale_out  output  2  committed scale mode: 0=1x, 1=2x, 2=8/3x; 3 is never driven.
- addr_out  output  17  frame-buffer read address.
- valid_out  output  1  pixel inside the scaled region, aligned to frame-buffer read data.

Behaviour:
- Reset (async, active-high):
  - scale_out=0, pending=0, addr_out=0, valid_out=0.
  - All pipeline registers cleared.
  - Reset mid-frame discards any pending request.
- Mode control (two registers, pending and scale_out):
  - btn_pulse_in: pending advances 0->1->2->0.
  - new_frame_in: scale_out <= pending.
  - Both in the same cycle: scale_out takes the pre-pulse pending; pending advances; the new value commits at the next new_frame_in.
  - Multiple button pulses within one frame accumulate modulo 3.
- Stage 1 (registered; uses the committed scale_out of that cycle):
  - Mode 0: region h<240 && v<320; src_x=h, src_y=v.
  - Mode 1: region h<480 && v<640; src_x=h>>1, src_y=v>>1.
  - Mode 2: region h<640 && v<853; src_x=(h*3)>>3, src_y=(v*3)>>3. Intermediates are 13 bits and are never truncated before the shift.
  - Outside region: src_x=src_y=0, region=0.
- Stage 2 (registered):
  - addr_out = src_y*FB_WIDTH + src_x.
  - Implemented as shift-subtract when FB_WIDTH=240: (y<<8)-(y<<4).
  - Result is 17 bits; maximum 76799.
  - Out-of-region pixels give addr_out=0.
- Latency:
  - addr_out is 2 cycles after hcount/vcount.
  - valid_out is 2+READ_LATENCY cycles after hcount/vcount, via a shift register carrying region.
- Pipeline runs every cycle (no stall); blanking pixels simply produce valid_out=0.
- A mode change takes effect on the pixel presented in the new_frame_in cycle's successor; pixels already in the pipeline finish under the old mode.

Optional Feature:
- Macro: SCALE_CTRL_BORDER_EN.
- Defined:
  - Adds output border_out (1 bit), high for pixels on the outermost row/column inside the active region, e.g. mode 0: h==0, h==239, v==0 or v==319.
  - border_out is aligned identically to valid_out and resets to 0.
- Undefined: the port does not exist and no extra logic is built.

Test Plan:
- Reset, mode 0, h=10 v=5 -> addr_out=1210 at +2 cycles, valid_out=1 at +4 cycles.
- Commit mode 1 (one pulse then new_frame), h=21 v=9 -> addr_out=970; h=480 v=9 -> valid_out=0, addr_out=0.
- Mode 2, h=639 v=852 -> addr_out=76799, valid_out=1; h=640 v=0 -> valid_out=0.
- btn_pulse_in and new_frame_in in the same cycle with pending=0 -> scale_out stays 0, pending=1; next new_frame_in -> scale_out=1.
- Three pulses in one frame -> scale_out unchanged at the next new_frame_in (wraps back to the same mode); assert rst_in mid-frame -> all outputs 0 immediately, without waiting for a clock edge.
- With SCALE_CTRL_BORDER_EN, mode 0, h=239 v=100 -> border_out=1 with valid_out=1; h=100 v=100 -> border_out=0.

Source files
------------

// File: rtl/scale_controller.sv
// Camera-scaling sequencer: frame-synchronous scale mode (1x/2x/8/3x) and frame-buffer read addressing.
// Optional macro SCALE_CTRL_BORDER_EN adds border_out, marking the outermost row/column of the scaled region.
module scale_controller #(
  parameter int FB_WIDTH     = 240,
  parameter int FB_HEIGHT    = 320,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        btn_pulse_in,
  input  logic        new_frame_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  output logic [1:0]  scale_out,
  output logic [16:0] addr_out,
`ifdef SCALE_CTRL_BORDER_EN
  output logic        border_out,
`endif
  output logic        valid_out
);

  localparam int XW = $clog2(FB_WIDTH);
  localparam int YW = $clog2(FB_HEIGHT);

  localparam logic [12:0] H_LIM_1X  = 13'(FB_WIDTH);
  localparam logic [12:0] V_LIM_1X  = 13'(FB_HEIGHT);
  localparam logic [12:0] H_LIM_2X  = 13'(2 * FB_WIDTH);
  localparam logic [12:0] V_LIM_2X  = 13'(2 * FB_HEIGHT);
  localparam logic [12:0] H_LIM_83X = 13'((FB_WIDTH * 8) / 3);
  localparam logic [12:0] V_LIM_83X = 13'((FB_HEIGHT * 8) / 3);

  typedef enum logic [1:0] {
    MODE_1X  = 2'd0,
    MODE_2X  = 2'd1,
    MODE_83X = 2'd2
  } mode_t;

  mode_t pending, pending_next, scale_q;

  assign scale_out = scale_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    pending_next = pending;
    if (btn_pulse_in) begin
      case (pending)
        MODE_1X: pending_next = MODE_2X;
        MODE_2X: pending_next = MODE_83X;
        default: pending_next = MODE_1X;
      endcase
    end
  end

  // NOTE: non-blocking assignments let scale_q sample the pre-pulse pending when both pulses coincide.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pending <= MODE_1X;
      scale_q <= MODE_1X;
    end else begin
      pending <= pending_next;
      if (new_frame_in) scale_q <= pending;
    end
  end

  // Stage 1: map display pixel to source pixel under the committed mode.
  logic [12:0]   h13, v13, h_x3, v_x3, h_lim, v_lim;
  logic [XW-1:0] sx_d, sx_s1;
  logic [YW-1:0] sy_d, sy_s1;
  logic          region_d, region_s1;

  assign h13  = {2'b00, hcount_in};
  assign v13  = {3'b000, vcount_in};
  assign h_x3 = h13 + (h13 << 1);
  assign v_x3 = v13 + (v13 << 1);

  always_comb begin
    h_lim = '0;
    v_lim = '0;
    sx_d  = '0;
    sy_d  = '0;
    case (scale_q)
      MODE_1X: begin
        h_lim = H_LIM_1X;
        v_lim = V_LIM_1X;
        sx_d  = XW'(h13);
        sy_d  = YW'(v13);
      end
      MODE_2X: begin
        h_lim = H_LIM_2X;
        v_lim = V_LIM_2X;
        sx_d  = XW'(h13 >> 1);
        sy_d  = YW'(v13 >> 1);
      end
      MODE_83X: begin
        h_lim = H_LIM_83X;
        v_lim = V_LIM_83X;
        sx_d  = XW'(h_x3 >> 3);
        sy_d  = YW'(v_x3 >> 3);
      end
      default: ;
    endcase
    region_d = (h13 < h_lim) && (v13 < v_lim);
    if (!region_d) begin
      sx_d = '0;
      sy_d = '0;
    end
  end

  // Stage 2: row base times FB_WIDTH, strength-reduced for the native 240-column buffer.
  logic [16:0] row_base, addr_d;
  logic [READ_LATENCY:0] valid_pipe;

  generate
    if (FB_WIDTH == 240) begin : g_shift_sub
      assign row_base = ({{(17-YW){1'b0}}, sy_s1} << 8) - ({{(17-YW){1'b0}}, sy_s1} << 4);
    end else begin : g_mult
      assign row_base = {{(17-YW){1'b0}}, sy_s1} * 17'(FB_WIDTH);
    end
  endgenerate

  assign addr_d    = row_base + {{(17-XW){1'b0}}, sx_s1};
  assign valid_out = valid_pipe[READ_LATENCY];

  // NOTE: the pipeline is small flops, not RAM, so it is fully reset to keep valid_out clean after reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      region_s1  <= 1'b0;
      sx_s1      <= '0;
      sy_s1      <= '0;
      addr_out   <= '0;
      valid_pipe <= '0;
    end else begin
      region_s1     <= region_d;
      sx_s1         <= sx_d;
      sy_s1         <= sy_d;
      addr_out      <= addr_d;
      valid_pipe[0] <= region_s1;
      for (int i = 1; i <= READ_LATENCY; i++) valid_pipe[i] <= valid_pipe[i-1];
    end
  end

`ifdef SCALE_CTRL_BORDER_EN
  logic                  border_d, border_s1;
  logic [READ_LATENCY:0] border_pipe;

  assign border_d   = region_d && ((h13 == '0) || (h13 == h_lim - 13'd1) ||
                                   (v13 == '0) || (v13 == v_lim - 13'd1));
  assign border_out = border_pipe[READ_LATENCY];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      border_s1   <= 1'b0;
      border_pipe <= '0;
    end else begin
      border_s1      <= border_d;
      border_pipe[0] <= border_s1;
      for (int i = 1; i <= READ_LATENCY; i++) border_pipe[i] <= border_pipe[i-1];
    end
  end
`endif

endmodule
